// File: rtl/dac_pkg.sv
// Shared constants for the multi-channel PWM DAC: default geometry and the
// counter-maximum helper used by the top and the per-channel slices.
package dac_pkg;

    localparam int DEFAULT_WIDTH    = 12;
    localparam int DEFAULT_CHANNELS = 2;

    // Last count of a WIDTH-bit period, i.e. 2^width - 1.
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair, phase compare and registered output.
// The active duty only reloads at the last count of this channel's own period.
module pwm_channel
    import dac_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_duty_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] phase_i,
    output logic             pwm_o
);

    localparam logic [WIDTH-1:0] PHASE_MAX = WIDTH'(cnt_max(WIDTH));

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        shadow_d = wr_en_i ? wr_duty_i : shadow_q;
        active_d = (phase_i == PHASE_MAX) ? shadow_q : active_q;
        // phase_i never exceeds PHASE_MAX, so duty 2^WIDTH-1 leaves exactly one low cycle.
        pwm_d    = en_i && (phase_i < active_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM DAC: shared free-running counter, duty-write decode and
// the once-per-period sample request with sticky underrun detection.
module pwm_dac_multi
    import dac_pkg::*;
#(
    parameter int  CHANNELS = DEFAULT_CHANNELS,
    parameter int  WIDTH    = DEFAULT_WIDTH,
    parameter int  STAGGER  = 0,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CW-1:0]       wr_chan,
    input  logic [WIDTH-1:0]    wr_duty,
    input  logic [CHANNELS-1:0] ch_en,
    output logic                req,
    input  logic                ack,
    output logic                underrun,
    output logic [CHANNELS-1:0] pwm
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));
    localparam int unsigned      SPACING = (32'd1 << WIDTH) / CHANNELS;

    logic [WIDTH-1:0]               cnt_q, cnt_d;
    logic                           req_q, req_d;
    logic                           underrun_q, underrun_d;
    logic [CHANNELS-1:0][WIDTH-1:0] phase;
    logic [CHANNELS-1:0]            at_max;
    logic [CHANNELS-1:0]            wr_sel;
    logic                           wrap;
    logic                           chan_ok;
    logic                           wr_fire;

    // Handshake: a write transfers on a rising edge where wr_valid && wr_ready.
    // wr_ready never depends on wr_valid; it drops only while some channel sits
    // on its period boundary so a write cannot race the shadow->active reload.
    assign wr_ready = rst && !(|at_max);
    assign chan_ok  = (int'(wr_chan) < CHANNELS);
    assign wr_fire  = wr_valid && wr_ready && chan_ok;
    assign wrap     = (cnt_q == CNT_MAX);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        localparam logic [WIDTH-1:0] OFFSET = (STAGGER != 0) ? WIDTH'(k * SPACING) : '0;

        assign phase[k]  = cnt_q + OFFSET;
        assign at_max[k] = (phase[k] == CNT_MAX);
        assign wr_sel[k] = wr_fire && (wr_chan == CW'(k));

        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk_i    (clk),
            .rst_ni   (rst),
            .wr_en_i  (wr_sel[k]),
            .wr_duty_i(wr_duty),
            .en_i     (ch_en[k]),
            .phase_i  (phase[k]),
            .pwm_o    (pwm[k])
        );
    end

    always_comb begin
        cnt_d      = cnt_q + WIDTH'(1);
        req_d      = req_q;
        underrun_d = underrun_q;
        // A wrap always raises a fresh request; an ack on that same edge only
        // spares the underrun flag.
        if (wrap) begin
            req_d = 1'b1;
            if (req_q && !ack) begin
                underrun_d = 1'b1;
            end
        end else if (req_q && ack) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            req_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            underrun_q <= underrun_d;
        end
    end

    assign req      = req_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_pwm_dac_multi.sv
// Bench for pwm_dac_multi at WIDTH=4: a plain-arithmetic period model tracks
// the default instance every cycle; staggered and 3-channel instances get directed checks.
module tb_pwm_dac_multi;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // default instance: CHANNELS=2, STAGGER=0
    logic       wr_valid, wr_ready, req, ack, underrun;
    logic [0:0] wr_chan;
    logic [3:0] wr_duty;
    logic [1:0] ch_en, pwm;

    // staggered instance: CHANNELS=2, STAGGER=1
    logic       s_wr_valid, s_wr_ready, s_req, s_ack, s_underrun;
    logic [0:0] s_wr_chan;
    logic [3:0] s_wr_duty;
    logic [1:0] s_ch_en, s_pwm;

    // three-channel instance
    logic       t_wr_valid, t_wr_ready, t_req, t_ack, t_underrun;
    logic [1:0] t_wr_chan;
    logic [3:0] t_wr_duty;
    logic [2:0] t_ch_en, t_pwm;

    pwm_dac_multi #(.CHANNELS(2), .WIDTH(4), .STAGGER(0)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan),
        .wr_duty(wr_duty), .ch_en(ch_en), .req(req), .ack(ack), .underrun(underrun), .pwm(pwm));

    pwm_dac_multi #(.CHANNELS(2), .WIDTH(4), .STAGGER(1)) dut_s (
        .clk(clk), .rst(rst), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_chan(s_wr_chan),
        .wr_duty(s_wr_duty), .ch_en(s_ch_en), .req(s_req), .ack(s_ack), .underrun(s_underrun),
        .pwm(s_pwm));

    pwm_dac_multi #(.CHANNELS(3), .WIDTH(4), .STAGGER(0)) dut_t (
        .clk(clk), .rst(rst), .wr_valid(t_wr_valid), .wr_ready(t_wr_ready), .wr_chan(t_wr_chan),
        .wr_duty(t_wr_duty), .ch_en(t_ch_en), .req(t_req), .ack(t_ack), .underrun(t_underrun),
        .pwm(t_pwm));

    // ---------------- scoreboard / model state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    int         m_cnt;          // cycles since release, mod 16
    int         m_sh[2];
    int         m_act[2];
    logic [1:0] m_pwm;
    bit         m_req, m_und;
    int         hc_m[2];
    int         hc_t[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input int got);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: got %0d expected <empty queue>", tag, got);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(got), 32'(e));
        end
    endtask

    // Period-level reference: duty d means phases 0..d-1 are high, shown one cycle late.
    task automatic model_step();
        bit boundary;
        if (!rst) begin
            m_cnt = 0;
            m_sh  = '{0, 0};
            m_act = '{0, 0};
            m_pwm = 2'b00;
            m_req = 1'b0;
            m_und = 1'b0;
        end else begin
            boundary = (m_cnt == 15);
            for (int k = 0; k < 2; k++) m_pwm[k] = ch_en[k] && (m_cnt < m_act[k]);
            if (boundary) for (int k = 0; k < 2; k++) m_act[k] = m_sh[k];
            if (wr_valid && !boundary) m_sh[int'(wr_chan)] = int'(wr_duty);
            if (boundary) begin
                if (m_req && !ack) m_und = 1'b1;
                m_req = 1'b1;
            end else if (m_req && ack) begin
                m_req = 1'b0;
            end
            m_cnt = (m_cnt + 1) % 16;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("pwm", 32'(pwm), 32'(m_pwm));
        chk("req", 32'(req), 32'(m_req));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("wr_ready", 32'(wr_ready), 32'(rst && (m_cnt != 15)));
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (m_cnt != target && n < 40);
    endtask

    function automatic logic ready_of(input int which);
        case (which)
            0:       return wr_ready;
            1:       return s_wr_ready;
            default: return t_wr_ready;
        endcase
    endfunction

    task automatic write(input int which, input int chan, input int duty);
        int n = 0;
        case (which)
            0:       begin wr_valid = 1'b1;   wr_chan = 1'(chan);   wr_duty = 4'(duty);   end
            1:       begin s_wr_valid = 1'b1; s_wr_chan = 1'(chan); s_wr_duty = 4'(duty); end
            default: begin t_wr_valid = 1'b1; t_wr_chan = 2'(chan); t_wr_duty = 4'(duty); end
        endcase
        while (!ready_of(which) && n < 40) begin
            cycle();
            n++;
        end
        chk("wr_handshake_wait", 32'(n < 40), 32'd1);
        cycle();
        wr_valid = 1'b0; s_wr_valid = 1'b0; t_wr_valid = 1'b0;
    endtask

    task automatic measure();
        hc_m = '{0, 0};
        hc_t = '{0, 0, 0};
        repeat (16) begin
            cycle();
            for (int k = 0; k < 2; k++) hc_m[k] += int'(pwm[k]);
            for (int k = 0; k < 3; k++) hc_t[k] += int'(t_pwm[k]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int r0, r1;
        logic [1:0] prev;

        rst = 1'b0; ack = 1'b0; wr_valid = 1'b0; wr_chan = '0; wr_duty = '0; ch_en = '0;
        s_wr_valid = 1'b0; s_wr_chan = '0; s_wr_duty = '0; s_ch_en = '0; s_ack = 1'b0;
        t_wr_valid = 1'b0; t_wr_chan = '0; t_wr_duty = '0; t_ch_en = '0; t_ack = 1'b0;
        @(negedge clk);
        repeat (3) cycle();
        chk("rst_pwm", 32'(pwm), 0);
        chk("rst_req", 32'(req), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_ready", 32'(wr_ready), 0);
        chk("rst_ready_t", 32'(t_wr_ready), 0);
        rst = 1'b1;
        #1;
        chk("ready_release", 32'(wr_ready), 1);

        // never ack: first request at the first wrap, underrun at the second
        repeat (15) cycle();
        chk("req_before_wrap", 32'(req), 0);
        cycle();
        chk("req_first_wrap", 32'(req), 1);
        chk("und_first_wrap", 32'(underrun), 0);
        repeat (16) cycle();
        chk("und_second_wrap", 32'(underrun), 1);
        chk("req_second_wrap", 32'(req), 1);
        rst = 1'b0;
        repeat (2) cycle();
        chk("und_cleared", 32'(underrun), 0);
        rst = 1'b1;

        // ack on the wrap edge keeps the request and spares underrun
        repeat (16) cycle();
        wait_cnt(15);
        ack = 1'b1;
        cycle();
        chk("ack_wrap_req", 32'(req), 1);
        chk("ack_wrap_und", 32'(underrun), 0);
        ack = 1'b0;
        cycle();
        ack = 1'b1;
        cycle();
        chk("ack_clear", 32'(req), 0);
        cycle();
        chk("ack_idle", 32'(req), 0);
        ack = 1'b0;

        // two channels with distinct duties
        ch_en = 2'b11;
        write(0, 0, 5);
        write(0, 1, 12);
        wait_cnt(0);
        chk("s1_cnt0", 32'(pwm), 0);
        cycle();
        chk("s1_start", 32'(pwm), 32'h3);
        exp_q.push_back(8'd5); exp_q.push_back(8'd12);
        measure();
        sb_check("s1_ch0_high", hc_m[0]);
        sb_check("s1_ch1_high", hc_m[1]);

        // mid-period write keeps the current period's duty
        wait_cnt(3);
        write(0, 0, 8);
        wait_cnt(7);
        chk("s2_old_duty", 32'(pwm[0]), 0);
        wait_cnt(15);
        chk("s2_ready_low", 32'(wr_ready), 0);
        wait_cnt(7);
        chk("s2_new_duty", 32'(pwm[0]), 1);
        exp_q.push_back(8'd8); exp_q.push_back(8'd12);
        measure();
        sb_check("s2_ch0_high", hc_m[0]);
        sb_check("s2_ch1_high", hc_m[1]);

        // duty extremes and enable removal mid-period
        write(0, 0, 0);
        write(0, 1, 15);
        wait_cnt(0);
        exp_q.push_back(8'd0); exp_q.push_back(8'd15);
        measure();
        sb_check("s4_duty0", hc_m[0]);
        sb_check("s4_duty15", hc_m[1]);
        wait_cnt(5);
        chk("s4_en_on", 32'(pwm[1]), 1);
        ch_en = 2'b01;
        cycle();
        chk("s4_en_off", 32'(pwm[1]), 0);
        ch_en = 2'b11;
        wait_cnt(0);
        exp_q.push_back(8'd0); exp_q.push_back(8'd15);
        measure();
        sb_check("s4_keep0", hc_m[0]);
        sb_check("s4_keep15", hc_m[1]);

        // randomized traffic checked cycle by cycle against the model
        repeat (300) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_chan  = 1'($urandom_range(0, 1));
            wr_duty  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ch_en = 2'($urandom_range(0, 3));
            ack = ($urandom_range(0, 3) == 0);
            cycle();
        end
        wr_valid = 1'b0; ack = 1'b0; ch_en = 2'b11;

        // staggered phases and an out-of-range channel write
        s_ch_en = 2'b11;
        t_ch_en = 3'b111;
        write(1, 0, 4);
        write(1, 1, 4);
        write(2, 0, 3);
        write(2, 1, 6);
        write(2, 2, 10);
        write(2, 3, 15);
        wait_cnt(0);
        wait_cnt(0);
        prev = s_pwm; r0 = -1; r1 = -1;
        repeat (16) begin
            cycle();
            if (s_pwm[0] && !prev[0] && r0 < 0) r0 = m_cnt;
            if (s_pwm[1] && !prev[1] && r1 < 0) r1 = m_cnt;
            if (m_cnt == 7) chk("stag_ready_low", 32'(s_wr_ready), 0);
            prev = s_pwm;
        end
        chk("stag_rise0", 32'(r0), 1);
        chk("stag_rise1", 32'(r1), 9);
        chk("stag_lead", 32'((r0 - r1 + 16) % 16), 8);
        exp_q.push_back(8'd3); exp_q.push_back(8'd6); exp_q.push_back(8'd10);
        measure();
        sb_check("c3_ch0_high", hc_t[0]);
        sb_check("c3_ch1_high", hc_t[1]);
        sb_check("c3_ch2_high", hc_t[2]);

        // reset mid-period with req and underrun both set
        wait_cnt(0);
        wait_cnt(0);
        wait_cnt(9);
        chk("pre_rst_req", 32'(req), 1);
        chk("pre_rst_und", 32'(underrun), 1);
        rst = 1'b0;
        wr_valid = 1'b1; wr_chan = 1'b0; wr_duty = 4'd9;
        cycle();
        chk("mid_rst_pwm", 32'(pwm), 0);
        chk("mid_rst_req", 32'(req), 0);
        chk("mid_rst_und", 32'(underrun), 0);
        chk("mid_rst_ready", 32'(wr_ready), 0);
        chk("mid_rst_pwm_s", 32'(s_pwm), 0);
        chk("mid_rst_pwm_t", 32'(t_pwm), 0);
        cycle();
        wr_valid = 1'b0;
        rst = 1'b1;
        repeat (15) cycle();
        chk("post_rst_no_req", 32'(req), 0);
        cycle();
        chk("post_rst_req", 32'(req), 1);
        exp_q.push_back(8'd0); exp_q.push_back(8'd0);
        measure();
        sb_check("post_rst_ch0", hc_m[0]);
        sb_check("post_rst_ch1", hc_m[1]);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_dac_multi.md
PWM_DAC_MULTI -- requirements
Module: pwm_dac_multi

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2, number of PWM outputs, legal range 1..8.
REQ-002 The block SHALL have parameter WIDTH, default 12, duty-cycle and counter width in bits, legal range 4..16.
REQ-003 The block SHALL have parameter STAGGER, default 0; 1 offsets channel k's phase by k*(2^WIDTH/CHANNELS) counts.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-low.
- wr_valid  in  1  duty-write request.
- wr_ready  out  1  duty write accepted this cycle when high together with wr_valid.
- wr_chan  in  max(1,$clog2(CHANNELS))  target channel index.
- wr_duty  in  WIDTH  new duty value.
- ch_en  in  CHANNELS  per-channel output enable.
- req  out  1  next-sample request, one per period.
- ack  in  1  sample-request acknowledge.
- underrun  out  1  sticky flag: a period started while req was still pending.
- pwm  out  CHANNELS  registered PWM outputs.

Function
REQ-005 A free-running WIDTH-bit counter cnt SHALL increment every cycle and wrap from 2^WIDTH-1 to 0.
REQ-006 Channel k's phase count cnt_k SHALL be cnt when STAGGER=0, else (cnt + k*(2^WIDTH/CHANNELS)) mod 2^WIDTH.
REQ-007 Each channel SHALL hold a shadow duty register and an active duty register, both WIDTH bits.
REQ-008 A write handshake (wr_valid && wr_ready) SHALL load wr_duty into shadow[wr_chan] at that clock edge.
REQ-009 A write with wr_chan >= CHANNELS SHALL be accepted (handshake completes) and discarded with no state change.
REQ-010 active[k] SHALL load shadow[k] on the edge where cnt_k == 2^WIDTH-1, so duty changes take effect only at period boundaries (glitch-free).
REQ-011 wr_ready SHALL be low in any cycle where cnt == 2^WIDTH-1 for any channel's cnt_k, and high otherwise (outside reset).
REQ-012 pwm[k] SHALL be registered as ch_en[k] && (cnt_k < active[k]), giving one cycle latency from cnt_k to output.
REQ-013 Duty 0 SHALL give constant low; duty 2^WIDTH-1 SHALL give 2^WIDTH-1 high cycles per 2^WIDTH-cycle period.
REQ-014 Deasserting ch_en[k] SHALL force pwm[k] low on the next edge without altering the counter or registers.
REQ-015 On the edge where cnt wraps to 0, req SHALL be set to 1.
REQ-016 req SHALL clear on the edge where ack is sampled high while req is high; ack while req is low SHALL be ignored.
REQ-017 If req is still high on a wrap to 0, underrun SHALL be set and stay set until reset; req SHALL remain high.
REQ-018 If ack and the wrap to 0 coincide while req is high, req SHALL stay 1 (new request) and underrun SHALL NOT be set.

Reset
REQ-019 While rst is low at a clock edge: cnt=0, all shadow=0, all active=0, pwm=0, req=0, underrun=0.
REQ-020 wr_ready SHALL be low while rst is low, and write attempts during reset SHALL be ignored.
REQ-021 Reset asserted mid-period SHALL abort the period; after release, counting SHALL restart from cnt=0 with the first req at the first wrap.

Structure
REQ-022 The default WIDTH and CHANNELS values and the counter-maximum constant SHALL live in the shared package dac_pkg.
REQ-023 Per-channel shadow/active registers, the compare and the output flop SHALL form sub-module pwm_channel, instantiated CHANNELS times.
REQ-024 The counter, write decode and req/ack/underrun logic SHALL reside in pwm_dac_multi.

Verification
REQ-025 Bench scenarios (WIDTH=4, CHANNELS=2 unless noted):
- Write ch0=5, ch1=12, ch_en=11 -> from the next period, pwm[0] high 5 of 16 cycles and pwm[1] high 12 of 16, pulses starting one cycle after cnt=0.
- Write ch0=8 at cnt=3 -> the current period keeps the old duty; the new duty applies from the next cnt=0; wr_ready is low at cnt=15.
- Never ack -> req rises at the first wrap and underrun sets at the second wrap; ack coinciding with a wrap -> req stays 1 and underrun stays 0.
- Duty 0 and duty 15, plus ch_en[1]=0 mid-period -> constant low / 15-of-16 high / pwm[1] low on the next edge.
- STAGGER=1 -> pwm[1] rising edges lead pwm[0] by 8 cycles; a write to wr_chan=3 with CHANNELS=3 is discarded.
- rst low at cnt=9 with req=1 and underrun=1 -> all outputs are 0 and registers cleared; after release, the first req comes 16 cycles later.
